dff_bank_arbiter: RTL
=====================

// Module: dff_bank_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer for one shared DATA_W-bit flop register.
//  NUM_REQ requesters compete for write access to the register.
//  Exactly one requester is granted per write slot; its data is committed to q.
//  After each write, a programmable gap enforces a minimum spacing before the
//  next write. Sits between producer blocks and the shared d_ff-style register.
// PARAMETERS
//  NUM_REQ  4  number of requesters (>=2)
//  DATA_W   3  width of the shared register and of each wdata lane
//  GAP_CYC  1  idle cycles inserted after every write (0 = back-to-back)
// PORTS
//  clk     in   1                single clock, all logic rising-edge
//  rst     in   1                synchronous reset, active-high
//  req     in   NUM_REQ          per-requester write request, level
//  wdata   in   NUM_REQ*DATA_W   lane i = wdata[i*DATA_W +: DATA_W]
//  gnt     out  NUM_REQ          registered one-hot grant, high for one cycle
//  q       out  DATA_W           shared register contents
//  q_src   out  $clog2(NUM_REQ)  index of the requester that last wrote q
//  q_upd   out  1                1-cycle pulse; high in the cycle after q changes
//  busy    out  1                high whenever state != IDLE
// BEHAVIOUR
//  Reset (rst=1 at a clk edge) forces: state=IDLE, gnt=0, q=0, q_src=0,
//   q_upd=0, busy=0, rr pointer ptr=0, gap counter=0. Reset dominates all events.
//  FSM states: IDLE, GRANT, GAP.
//  Arbitration: search req starting at ptr, ascending, wrapping NUM_REQ-1 -> 0.
//   The first set bit wins, giving sel.
//   Arbitration is evaluated in three places:
//    - in IDLE;
//    - in GRANT when GAP_CYC=0;
//    - in the last GAP cycle.
//   If a winner exists: next state=GRANT, gnt<=onehot(sel).
//   If no winner exists: next state=IDLE.
//  GRANT (exactly 1 cycle): gnt is high for sel.
//   At the closing edge: q<=wdata lane sel, q_src<=sel,
//   ptr<=(sel+1) mod NUM_REQ, q_upd<=1.
//   Then go to GAP (counter<=GAP_CYC) if GAP_CYC>0, else arbitrate as above.
//  GAP: hold for GAP_CYC cycles, gnt=0. Arbitration runs in the final cycle.
//  Latency: a req first seen in IDLE gets gnt on the next cycle.
//   q updates at the end of the gnt cycle; q_upd is high the cycle after.
//  Throughput: one write per 1+GAP_CYC cycles under continuous requests.
//  Grant is committed once gnt is high. Dropping req during the gnt cycle does
//   not cancel the write; wdata is sampled at that cycle's closing edge.
//  A requester must hold req and wdata stable until it sees gnt.
//   If it keeps req high after its grant, it is re-granted only when its
//   round-robin turn returns.
//  req changes during GAP are ignored until the final GAP cycle.
//  rst asserted during GRANT: no write occurs, q/q_src are reset to 0,
//   q_upd stays 0, gnt=0 on the next cycle.
//  gnt is never multi-hot. gnt=0 in IDLE and GAP.
// TESTING
//  (NUM_REQ=4, DATA_W=3, GAP_CYC=1 unless noted)
//  1 Reset: rst=1 for 2 cycles, req=4'b1111
//    -> gnt=0, q=0, q_src=0, q_upd=0, busy=0 throughout.
//  2 Single request: req=4'b0100, lane2=5 from IDLE
//    -> next cycle gnt=4'b0100; then q=5, q_src=2, q_upd=1 for 1 cycle; ptr=3.
//  3 Fairness: req=4'b1111 held, lanes=4,5,6,7
//    -> gnt 0001,0010,0100,1000,0001 every 2 cycles; q follows 4,5,6,7,4.
//    With GAP_CYC=0: a grant every cycle.
//  4 Wrap: after a grant to 2, present req=4'b0101
//    -> gnt=4'b0001 first (search order 3,0,1,2), then 4'b0100.
//  5 Reset mid-op: rst=1 during the GRANT cycle for lane1 (data 6)
//    -> q=0, q_upd stays 0, gnt=0, busy=0 on the next cycle.
//  6 Req drop: req[1] deasserted in its gnt cycle, lane1=3
//    -> q=3, q_src=1, q_upd pulses; no second grant to 1.

Source files
------------

// File: rtl/dff_bank_arbiter_if.sv
// Requester-side bundle for the shared-register arbiter: level requests and data
// lanes in, one-hot grant plus the committed register state out.
interface dff_bank_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 3
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [DATA_W-1:0]         q;
    logic [IDX_W-1:0]          q_src;
    logic                      q_upd;
    logic                      busy;

    modport master (output req, wdata, input gnt, q, q_src, q_upd, busy);
    modport slave  (input req, wdata, output gnt, q, q_src, q_upd, busy);
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter that commits one requester lane per slot into a shared register.
// Grant one cycle after a request is seen in IDLE; requesters hold req/wdata until granted.
module dff_bank_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 3,
    parameter int GAP_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    dff_bank_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (GAP_CYC < 1) ? 1 : $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [DATA_W-1:0]  q_q, q_d;
    logic [IDX_W-1:0]   q_src_q, q_src_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic               q_upd_q, q_upd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [IDX_W-1:0]   ptr_nxt;
    logic [IDX_W-1:0]   arb_ptr;
    logic [IDX_W-1:0]   arb_sel;
    logic               arb_hit;
    logic               arb_en;

    assign ptr_nxt = (sel_q == IDX_W'(NUM_REQ - 1)) ? '0 : sel_q + IDX_W'(1);
    // While a grant is closing, the search must already start past the winner.
    assign arb_ptr = (state_q == GRANT) ? ptr_nxt : ptr_q;

    always_comb begin
        int idx;
        idx     = 0;
        arb_hit = 1'b0;
        arb_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(arb_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!arb_hit && bus.req[idx]) begin
                arb_hit = 1'b1;
                arb_sel = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        q_d     = q_q;
        q_src_d = q_src_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        q_upd_d = 1'b0;
        cnt_d   = cnt_q;
        arb_en  = 1'b0;
        case (state_q)
            IDLE: arb_en = 1'b1;
            GRANT: begin
                q_d     = bus.wdata[sel_q*DATA_W +: DATA_W];
                q_src_d = sel_q;
                ptr_d   = ptr_nxt;
                q_upd_d = 1'b1;
                if (GAP_CYC > 0) begin
                    state_d = GAP;
                    cnt_d   = CNT_W'(GAP_CYC);
                end else begin
                    arb_en = 1'b1;
                end
            end
            GAP: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) arb_en = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (arb_en) begin
            if (arb_hit) begin
                state_d = GRANT;
                gnt_d   = NUM_REQ'(1) << arb_sel;
                sel_d   = arb_sel;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            q_q     <= '0;
            q_src_q <= '0;
            ptr_q   <= '0;
            sel_q   <= '0;
            q_upd_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            q_q     <= q_d;
            q_src_q <= q_src_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            q_upd_q <= q_upd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.q     = q_q;
    assign bus.q_src = q_src_q;
    assign bus.q_upd = q_upd_q;
    assign bus.busy  = (state_q != IDLE);
endmodule
